// File: rtl/rb_pkg.sv
// Shared types for the DDR4 ring-buffer burst scheduler.
package rb_pkg;

  typedef enum logic [2:0] {
    ST_INIT, ST_IDLE, ST_WR_CMD, ST_WR_WAIT, ST_RD_CMD, ST_RD_WAIT, ST_ERR
  } sched_state_t;

  typedef enum logic {GNT_WR = 1'b0, GNT_RD = 1'b1} grant_t;

  localparam logic [1:0]  AXI_RESP_OKAY   = 2'b00;
  localparam int unsigned DEF_BURST_BYTES = 4096;

endpackage

// File: rtl/rb_burst_sched_if.sv
// Command/completion handshake between the scheduler and the AXI burst engines.
interface rb_burst_sched_if #(parameter int ADDR_W = 31);

  logic              wr_cmd_valid;
  logic              wr_cmd_ready;
  logic [ADDR_W-1:0] wr_cmd_addr;
  logic              wr_done;
  logic              wr_err;
  logic              rd_cmd_valid;
  logic              rd_cmd_ready;
  logic [ADDR_W-1:0] rd_cmd_addr;
  logic              rd_done;
  logic              rd_err;

  modport master (
    output wr_cmd_valid, wr_cmd_addr, rd_cmd_valid, rd_cmd_addr,
    input  wr_cmd_ready, wr_done, wr_err, rd_cmd_ready, rd_done, rd_err
  );

  modport slave (
    input  wr_cmd_valid, wr_cmd_addr, rd_cmd_valid, rd_cmd_addr,
    output wr_cmd_ready, wr_done, wr_err, rd_cmd_ready, rd_done, rd_err
  );

endinterface

// File: rtl/rb_sched_arb.sv
// Two-requester round-robin arbiter; near-full occupancy forces the read side.
module rb_sched_arb
  import rb_pkg::*;
(
  input  logic   can_wr,
  input  logic   can_rd,
  input  logic   hi_wm_hit,
  input  grant_t last_grant,
  output logic   gnt_valid,
  output grant_t gnt
);

  always_comb begin
    gnt_valid = can_wr | can_rd;
    gnt       = GNT_WR;
    if (can_wr && can_rd)
      gnt = hi_wm_hit ? GNT_RD : ((last_grant == GNT_RD) ? GNT_WR : GNT_RD);
    else if (can_rd)
      gnt = GNT_RD;
  end

endmodule

// File: rtl/rb_burst_sched.sv
// Ring-buffer burst scheduler: one outstanding DDR4 burst at a time.
// Optional counters enabled by defining RB_SCHED_STATS_EN.
module rb_burst_sched
  import rb_pkg::*;
#(
  parameter int                ADDR_W          = 31,
  parameter logic [ADDR_W-1:0] BASE_ADDR       = '0,
  parameter int                BURST_BYTES     = DEF_BURST_BYTES,
  parameter int                LOG2_NUM_BURSTS = 19,
  parameter int                HI_WM           = 2**LOG2_NUM_BURSTS - 4
) (
  input  logic                     ddr4_clk,
  input  logic                     ddr4_rst,
  input  logic                     ddr4_ready,
  input  logic                     wr_avail,
  input  logic                     rd_space,
  rb_burst_sched_if.master         bus,
  output logic [LOG2_NUM_BURSTS:0] occupancy,
  output logic                     sys_ready,
  output logic                     sys_full,
  output logic                     sys_empty,
  output logic                     sys_error,
  output logic [31:0]              stat_wr_bursts,
  output logic [31:0]              stat_rd_bursts,
  output logic [LOG2_NUM_BURSTS:0] stat_peak_occ
);

  localparam int                         PW      = LOG2_NUM_BURSTS;
  localparam int                         OCC_W   = LOG2_NUM_BURSTS + 1;
  localparam int                         BB_SH   = $clog2(BURST_BYTES);
  localparam logic [OCC_W-1:0]           SLOTS   = OCC_W'(2**LOG2_NUM_BURSTS);
  localparam logic [OCC_W-1:0]           HI_WM_V = OCC_W'(HI_WM);
  localparam logic [OCC_W-1:0]           OCC_ONE = OCC_W'(1);
  localparam logic [PW-1:0]              PTR_ONE = PW'(1);

  sched_state_t     state;
  grant_t           last_grant;
  grant_t           gnt;
  logic             gnt_valid;
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [OCC_W-1:0] occ_nxt;
  logic             can_wr, can_rd, hi_wm_hit;
  logic             wr_ok, wr_bad, rd_ok, rd_bad;

  function automatic logic [ADDR_W-1:0] slot_addr(input logic [PW-1:0] p);
    return BASE_ADDR + (ADDR_W'(p) << BB_SH);
  endfunction

  assign can_wr    = wr_avail & ~sys_full;
  assign can_rd    = rd_space & ~sys_empty;
  assign hi_wm_hit = occupancy >= HI_WM_V;

  // Done pulses only count in the matching wait state.
  assign wr_ok  = (state == ST_WR_WAIT) && bus.wr_done && !bus.wr_err;
  assign wr_bad = (state == ST_WR_WAIT) && bus.wr_done &&  bus.wr_err;
  assign rd_ok  = (state == ST_RD_WAIT) && bus.rd_done && !bus.rd_err;
  assign rd_bad = (state == ST_RD_WAIT) && bus.rd_done &&  bus.rd_err;

  always_comb begin
    occ_nxt = occupancy;
    if (wr_ok)      occ_nxt = occupancy + OCC_ONE;
    else if (rd_ok) occ_nxt = occupancy - OCC_ONE;
  end

  rb_sched_arb u_arb (
    .can_wr     (can_wr),
    .can_rd     (can_rd),
    .hi_wm_hit  (hi_wm_hit),
    .last_grant (last_grant),
    .gnt_valid  (gnt_valid),
    .gnt        (gnt)
  );

  always_ff @(posedge ddr4_clk) begin
    if (ddr4_rst) begin
      state            <= ST_INIT;
      last_grant       <= GNT_RD;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      occupancy        <= '0;
      sys_ready        <= 1'b0;
      sys_full         <= 1'b0;
      sys_empty        <= 1'b1;
      sys_error        <= 1'b0;
      bus.wr_cmd_valid <= 1'b0;
      bus.wr_cmd_addr  <= '0;
      bus.rd_cmd_valid <= 1'b0;
      bus.rd_cmd_addr  <= '0;
    end else begin
      occupancy <= occ_nxt;
      sys_full  <= (occ_nxt == SLOTS);
      sys_empty <= (occ_nxt == '0);
      if (wr_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_ok) rd_ptr <= rd_ptr + PTR_ONE;

      case (state)
        ST_INIT: if (ddr4_ready) begin
          state     <= ST_IDLE;
          sys_ready <= 1'b1;
        end
        ST_IDLE: begin
          if (!ddr4_ready) begin
            state     <= ST_INIT;
            sys_ready <= 1'b0;
          end else if (gnt_valid) begin
            last_grant <= gnt;
            if (gnt == GNT_WR) begin
              state            <= ST_WR_CMD;
              bus.wr_cmd_valid <= 1'b1;
              bus.wr_cmd_addr  <= slot_addr(wr_ptr);
            end else begin
              state            <= ST_RD_CMD;
              bus.rd_cmd_valid <= 1'b1;
              bus.rd_cmd_addr  <= slot_addr(rd_ptr);
            end
          end
        end
        // A command once offered stays up even if calibration drops.
        ST_WR_CMD: if (bus.wr_cmd_ready) begin
          state            <= ST_WR_WAIT;
          bus.wr_cmd_valid <= 1'b0;
        end
        ST_RD_CMD: if (bus.rd_cmd_ready) begin
          state            <= ST_RD_WAIT;
          bus.rd_cmd_valid <= 1'b0;
        end
        ST_WR_WAIT: begin
          if (wr_bad) begin
            state     <= ST_ERR;
            sys_ready <= 1'b0;
            sys_error <= 1'b1;
          end else if (wr_ok) begin
            state     <= ddr4_ready ? ST_IDLE : ST_INIT;
            sys_ready <= ddr4_ready;
          end
        end
        ST_RD_WAIT: begin
          if (rd_bad) begin
            state     <= ST_ERR;
            sys_ready <= 1'b0;
            sys_error <= 1'b1;
          end else if (rd_ok) begin
            state     <= ddr4_ready ? ST_IDLE : ST_INIT;
            sys_ready <= ddr4_ready;
          end
        end
        ST_ERR: ;
        default: begin
          state     <= ST_INIT;
          sys_ready <= 1'b0;
        end
      endcase
    end
  end

`ifdef RB_SCHED_STATS_EN
  always_ff @(posedge ddr4_clk) begin
    if (ddr4_rst) begin
      stat_wr_bursts <= '0;
      stat_rd_bursts <= '0;
      stat_peak_occ  <= '0;
    end else begin
      if (wr_ok && stat_wr_bursts != '1) stat_wr_bursts <= stat_wr_bursts + 32'd1;
      if (rd_ok && stat_rd_bursts != '1) stat_rd_bursts <= stat_rd_bursts + 32'd1;
      if (occ_nxt > stat_peak_occ)       stat_peak_occ  <= occ_nxt;
    end
  end
`else
  assign stat_wr_bursts = '0;
  assign stat_rd_bursts = '0;
  assign stat_peak_occ  = '0;
`endif

endmodule

// File: tb/tb_rb_burst_sched.sv
// Self-checking bench for rb_burst_sched on a 4-slot ring at base 0x1000.
module tb_rb_burst_sched;

  localparam int AW = 31;

  logic          clk = 1'b0;
  logic          rst, ddr4_ready, wr_avail, rd_space;
  logic [2:0]    occupancy, stat_peak_occ;
  logic          sys_ready, sys_full, sys_empty, sys_error;
  logic [31:0]   stat_wr_bursts, stat_rd_bursts;

  int errors = 0;
  int checks = 0;

  // Reference model: slot indices, stored count, who was granted last.
  int m_wr, m_rd, m_occ, m_nwr, m_nrd;
  bit m_last_wr;

  rb_burst_sched_if #(.ADDR_W(AW)) bus ();

  rb_burst_sched #(
    .ADDR_W(AW), .BASE_ADDR(31'h1000), .BURST_BYTES(4096),
    .LOG2_NUM_BURSTS(2), .HI_WM(3)
  ) dut (
    .ddr4_clk(clk), .ddr4_rst(rst), .ddr4_ready(ddr4_ready),
    .wr_avail(wr_avail), .rd_space(rd_space), .bus(bus),
    .occupancy(occupancy), .sys_ready(sys_ready), .sys_full(sys_full),
    .sys_empty(sys_empty), .sys_error(sys_error),
    .stat_wr_bursts(stat_wr_bursts), .stat_rd_bursts(stat_rd_bursts),
    .stat_peak_occ(stat_peak_occ)
  );

  always #5 clk = ~clk;

  function automatic logic [AW-1:0] slot_addr(input int s);
    return AW'(32'h1000 + s * 4096);
  endfunction

  function automatic bit exp_is_wr(input bit wa, input bit rs);
    bit cw, cr;
    cw = wa && (m_occ < 4);
    cr = rs && (m_occ > 0);
    if (cw && !cr) return 1'b1;
    if (cr && !cw) return 1'b0;
    if (m_occ >= 3) return 1'b0;
    return !m_last_wr;
  endfunction

  task automatic model_reset();
    m_wr = 0; m_rd = 0; m_occ = 0; m_nwr = 0; m_nrd = 0; m_last_wr = 1'b0;
  endtask

  task automatic model_commit(input bit w);
    if (w) begin m_wr = (m_wr + 1) % 4; m_occ++; m_nwr++; end
    else   begin m_rd = (m_rd + 1) % 4; m_occ--; m_nrd++; end
    m_last_wr = w;
  endtask

  // Plays both burst engines for one burst; called and returns on a negedge.
  task automatic do_burst(input bit wa, input bit rs, input int rdy, input int dd,
                          input bit er, output bit is_wr, output logic [AW-1:0] addr,
                          output bit to);
    int n = 0;
    wr_avail = wa; rd_space = rs; to = 1'b0; is_wr = 1'b0; addr = '0;
    while (!(bus.wr_cmd_valid || bus.rd_cmd_valid) && n < 64) begin
      @(negedge clk); n++;
    end
    if (n >= 64) begin
      to = 1'b1; wr_avail = 1'b0; rd_space = 1'b0;
      return;
    end
    is_wr = bus.wr_cmd_valid;
    addr  = is_wr ? bus.wr_cmd_addr : bus.rd_cmd_addr;
    repeat (rdy) @(negedge clk);
    if (is_wr) bus.wr_cmd_ready = 1'b1; else bus.rd_cmd_ready = 1'b1;
    @(negedge clk);
    bus.wr_cmd_ready = 1'b0; bus.rd_cmd_ready = 1'b0;
    repeat (dd) @(negedge clk);
    if (is_wr) begin bus.wr_done = 1'b1; bus.wr_err = er; end
    else       begin bus.rd_done = 1'b1; bus.rd_err = er; end
    @(negedge clk);
    bus.wr_done = 1'b0; bus.wr_err = 1'b0; bus.rd_done = 1'b0; bus.rd_err = 1'b0;
    wr_avail = 1'b0; rd_space = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.wr_cmd_valid, bus.rd_cmd_valid, sys_ready, sys_full, sys_error} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got wv=%0b rv=%0b rdy=%0b full=%0b err=%0b, want all 0",
               bus.wr_cmd_valid, bus.rd_cmd_valid, sys_ready, sys_full, sys_error);
    end
    checks++;
    if (occupancy !== 3'd0 || sys_empty !== 1'b1) begin
      errors++;
      $display("FAIL reset_occ: got occ=%0d empty=%0b, want 0/1", occupancy, sys_empty);
    end
    checks++;
    if (stat_wr_bursts !== 32'd0 || stat_rd_bursts !== 32'd0 || stat_peak_occ !== 3'd0) begin
      errors++;
      $display("FAIL reset_stats: got %0d/%0d/%0d, want 0/0/0",
               stat_wr_bursts, stat_rd_bursts, stat_peak_occ);
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_init();
    bit w, to, seen;
    logic [AW-1:0] a;
    wr_avail = 1'b1; seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.wr_cmd_valid) seen = 1'b1;
    end
    checks++;
    if (seen || sys_ready !== 1'b0) begin
      errors++;
      $display("FAIL init_hold: got cmd_seen=%0b rdy=%0b, want 0/0", seen, sys_ready);
    end
    ddr4_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (sys_ready !== 1'b1 || bus.wr_cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL init_idle: got rdy=%0b wv=%0b, want 1/0", sys_ready, bus.wr_cmd_valid);
    end
    @(negedge clk);
    checks++;
    if (bus.wr_cmd_valid !== 1'b1 || bus.wr_cmd_addr !== 31'h1000) begin
      errors++;
      $display("FAIL init_first_cmd: got wv=%0b addr=%0h, want 1/1000",
               bus.wr_cmd_valid, bus.wr_cmd_addr);
    end
    do_burst(1'b1, 1'b0, 0, 1, 1'b0, w, a, to);
    model_commit(1'b1);
    checks++;
    if (to || occupancy !== 3'd1) begin
      errors++;
      $display("FAIL init_occ: got occ=%0d to=%0b, want 1/0", occupancy, to);
    end
  endtask

  task automatic test_fill_wrap();
    bit w, to, seen;
    logic [AW-1:0] a, ea;
    for (int i = 1; i < 4; i++) begin
      ea = AW'(32'h1000 + i * 32'h1000);
      do_burst(1'b1, 1'b0, 0, 2, 1'b0, w, a, to);
      model_commit(1'b1);
      checks++;
      if (to || w !== 1'b1 || a !== ea) begin
        errors++;
        $display("FAIL fill_wr[%0d]: got wr=%0b addr=%0h to=%0b, want wr=1 addr=%0h", i, w, a, to, ea);
      end
    end
    checks++;
    if (occupancy !== 3'd4 || sys_full !== 1'b1 || sys_empty !== 1'b0) begin
      errors++;
      $display("FAIL fill_full: got occ=%0d full=%0b empty=%0b, want 4/1/0", occupancy, sys_full, sys_empty);
    end
    wr_avail = 1'b1; seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.wr_cmd_valid || bus.rd_cmd_valid) seen = 1'b1;
    end
    wr_avail = 1'b0;
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL fill_no_fifth: got a command while full, want none");
    end
    for (int i = 0; i < 4; i++) begin
      ea = AW'(32'h1000 + i * 32'h1000);
      do_burst(1'b0, 1'b1, 1, 0, 1'b0, w, a, to);
      model_commit(1'b0);
      checks++;
      if (to || w !== 1'b0 || a !== ea) begin
        errors++;
        $display("FAIL drain_rd[%0d]: got wr=%0b addr=%0h to=%0b, want wr=0 addr=%0h", i, w, a, to, ea);
      end
    end
    checks++;
    if (occupancy !== 3'd0 || sys_empty !== 1'b1 || sys_full !== 1'b0) begin
      errors++;
      $display("FAIL drain_empty: got occ=%0d empty=%0b full=%0b, want 0/1/0", occupancy, sys_empty, sys_full);
    end
    do_burst(1'b1, 1'b0, 0, 0, 1'b0, w, a, to);
    model_commit(1'b1);
    checks++;
    if (to || w !== 1'b1 || a !== 31'h1000) begin
      errors++;
      $display("FAIL wrap_wr: got wr=%0b addr=%0h to=%0b, want wr=1 addr=1000", w, a, to);
    end
  endtask

  task automatic test_arb();
    bit w, to, ew;
    logic [AW-1:0] a, ea;
    bit exp_hi [3] = '{1'b0, 1'b0, 1'b1};
    // Reach occupancy 1 with the last grant going to read.
    do_burst(1'b1, 1'b0, 0, 1, 1'b0, w, a, to); model_commit(1'b1);
    do_burst(1'b0, 1'b1, 0, 1, 1'b0, w, a, to); model_commit(1'b0);
    for (int i = 0; i < 4; i++) begin
      ew = (i % 2 == 0);
      ea = slot_addr(ew ? m_wr : m_rd);
      do_burst(1'b1, 1'b1, 0, 1, 1'b0, w, a, to);
      model_commit(ew);
      checks++;
      if (to || w !== ew || a !== ea) begin
        errors++;
        $display("FAIL arb_rr[%0d]: got wr=%0b addr=%0h to=%0b, want wr=%0b addr=%0h", i, w, a, to, ew, ea);
      end
    end
    for (int i = 0; i < 3; i++) begin
      do_burst(1'b1, 1'b0, 0, 0, 1'b0, w, a, to); model_commit(1'b1);
    end
    // From full: read, read again at the watermark, then back to write.
    for (int i = 0; i < 3; i++) begin
      ew = exp_hi[i];
      ea = slot_addr(ew ? m_wr : m_rd);
      do_burst(1'b1, 1'b1, 0, 1, 1'b0, w, a, to);
      model_commit(ew);
      checks++;
      if (to || w !== ew || a !== ea) begin
        errors++;
        $display("FAIL arb_hiwm[%0d]: got wr=%0b addr=%0h to=%0b, want wr=%0b addr=%0h", i, w, a, to, ew, ea);
      end
    end
  endtask

  task automatic test_handshake();
    bit w, to, stable;
    logic [AW-1:0] a, a0, ea;
    int n = 0;
    int occ0;
    wr_avail = 1'b1; rd_space = 1'b0;
    while (!bus.wr_cmd_valid && n < 64) begin @(negedge clk); n++; end
    a0 = bus.wr_cmd_addr; stable = (n < 64);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (bus.wr_cmd_valid !== 1'b1 || bus.wr_cmd_addr !== a0) stable = 1'b0;
    end
    checks++;
    if (!stable || a0 !== slot_addr(m_wr)) begin
      errors++;
      $display("FAIL hs_stable: got stable=%0b addr=%0h, want 1/%0h", stable, a0, slot_addr(m_wr));
    end
    bus.wr_cmd_ready = 1'b1;
    @(negedge clk);
    bus.wr_cmd_ready = 1'b0; wr_avail = 1'b0;
    occ0 = m_occ;
    bus.rd_done = 1'b1;
    @(negedge clk);
    bus.rd_done = 1'b0;
    @(negedge clk);
    checks++;
    if (occupancy !== occ0[2:0]) begin
      errors++;
      $display("FAIL hs_stray_done: got occ=%0d, want %0d", occupancy, occ0);
    end
    bus.wr_done = 1'b1;
    @(negedge clk);
    bus.wr_done = 1'b0;
    model_commit(1'b1);
    ea = slot_addr(m_rd);
    do_burst(1'b0, 1'b1, 0, 0, 1'b0, w, a, to);
    model_commit(1'b0);
    checks++;
    if (to || w !== 1'b0 || a !== ea) begin
      errors++;
      $display("FAIL hs_rd_ptr: got wr=%0b addr=%0h to=%0b, want wr=0 addr=%0h", w, a, to, ea);
    end
  endtask

  task automatic test_random();
    bit w, to, ew, wa, rs;
    logic [AW-1:0] a, ea;
    for (int i = 0; i < 40; i++) begin
      do begin
        wa = 1'($urandom_range(0, 1));
        rs = 1'($urandom_range(0, 1));
      end while (!((wa && m_occ < 4) || (rs && m_occ > 0)));
      ew = exp_is_wr(wa, rs);
      ea = slot_addr(ew ? m_wr : m_rd);
      do_burst(wa, rs, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0, w, a, to);
      model_commit(ew);
      checks++;
      if (to || w !== ew || a !== ea) begin
        errors++;
        $display("FAIL rand_grant[%0d]: got wr=%0b addr=%0h to=%0b, want wr=%0b addr=%0h", i, w, a, to, ew, ea);
      end
      checks++;
      if (occupancy !== m_occ[2:0] || sys_full !== (m_occ == 4) || sys_empty !== (m_occ == 0)) begin
        errors++;
        $display("FAIL rand_occ[%0d]: got occ=%0d full=%0b empty=%0b, want occ=%0d", i,
                 occupancy, sys_full, sys_empty, m_occ);
      end
    end
    checks++;
`ifdef RB_SCHED_STATS_EN
    if (stat_wr_bursts !== 32'(m_nwr) || stat_rd_bursts !== 32'(m_nrd)) begin
      errors++;
      $display("FAIL stats: got wr=%0d rd=%0d, want wr=%0d rd=%0d", stat_wr_bursts, stat_rd_bursts, m_nwr, m_nrd);
    end
`else
    if (stat_wr_bursts !== 32'd0 || stat_rd_bursts !== 32'd0) begin
      errors++;
      $display("FAIL stats_off: got wr=%0d rd=%0d, want 0/0", stat_wr_bursts, stat_rd_bursts);
    end
`endif
  endtask

  task automatic test_error();
    bit w, to, seen;
    logic [AW-1:0] a;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    do_burst(1'b1, 1'b0, 0, 1, 1'b0, w, a, to);
    do_burst(1'b1, 1'b0, 0, 1, 1'b1, w, a, to);
    checks++;
    if (to || sys_error !== 1'b1 || sys_ready !== 1'b0 || occupancy !== 3'd1) begin
      errors++;
      $display("FAIL err_flags: got err=%0b rdy=%0b occ=%0d to=%0b, want 1/0/1/0",
               sys_error, sys_ready, occupancy, to);
    end
    wr_avail = 1'b1; rd_space = 1'b1; seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.wr_cmd_valid || bus.rd_cmd_valid) seen = 1'b1;
    end
    wr_avail = 1'b0; rd_space = 1'b0;
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL err_no_cmd: got a command in error state, want none");
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({sys_error, sys_ready, sys_full, sys_empty} !== 4'b0001 || occupancy !== 3'd0) begin
      errors++;
      $display("FAIL err_reset: got err=%0b rdy=%0b full=%0b empty=%0b occ=%0d, want 0/0/0/1/0",
               sys_error, sys_ready, sys_full, sys_empty, occupancy);
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset_mid();
    bit w, to;
    logic [AW-1:0] a;
    int n = 0;
    do_burst(1'b1, 1'b0, 0, 0, 1'b0, w, a, to);
    do_burst(1'b1, 1'b0, 0, 0, 1'b0, w, a, to);
    checks++;
    if (to || occupancy !== 3'd2) begin
      errors++;
      $display("FAIL mid_setup: got occ=%0d to=%0b, want 2/0", occupancy, to);
    end
    rd_space = 1'b1;
    while (!bus.rd_cmd_valid && n < 64) begin @(negedge clk); n++; end
    bus.rd_cmd_ready = 1'b1;
    @(negedge clk);
    bus.rd_cmd_ready = 1'b0; rd_space = 1'b0;
    rst = 1'b1; ddr4_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (occupancy !== 3'd0 || bus.rd_cmd_valid !== 1'b0 || sys_ready !== 1'b0 || sys_empty !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset: got occ=%0d rv=%0b rdy=%0b empty=%0b, want 0/0/0/1",
               occupancy, bus.rd_cmd_valid, sys_ready, sys_empty);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (sys_ready !== 1'b0 || bus.wr_cmd_valid !== 1'b0 || bus.rd_cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_init: got rdy=%0b wv=%0b rv=%0b, want 0/0/0",
               sys_ready, bus.wr_cmd_valid, bus.rd_cmd_valid);
    end
  endtask

  initial begin
    rst = 1'b1; ddr4_ready = 1'b0; wr_avail = 1'b0; rd_space = 1'b0;
    bus.wr_cmd_ready = 1'b0; bus.wr_done = 1'b0; bus.wr_err = 1'b0;
    bus.rd_cmd_ready = 1'b0; bus.rd_done = 1'b0; bus.rd_err = 1'b0;
    test_reset();
    test_init();
    test_fill_wrap();
    test_arb();
    test_handshake();
    test_random();
    test_error();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
